// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM state encoding,
// memRead/memWrite request codes and the wait-counter width.
package mem_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_PORT_WAIT,
        ST_DONE
    } state_t;

    // memReadIn / memWriteIn encodings
    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_SRAM = 2'b01;
    localparam logic [1:0] ACC_PORT = 2'b10;
    localparam logic [1:0] ACC_NOP  = 2'b11;

    // Width of the shared RD/WR wait counter
    localparam int CNT_W = 8;

    // True when a request code asks for a real bus access
    function automatic logic is_access(input logic [1:0] code);
        return (code != ACC_NONE) && (code != ACC_NOP);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_counter.sv
// Down-counter used to time the SRAM read-wait and write-pulse phases.
// Load has priority; decrement stops at zero.
module mem_wait_counter
    import mem_stage_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load a phase length, then count down towards zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller. Turns latched EX/MEM memRead/memWrite requests into
// multi-cycle SRAM or I/O-port bus cycles, freezes the pipeline while an access
// is in flight and returns read data with a one-cycle done pulse.
// Handshake: a request is any memReadIn/memWriteIn code of 01/10 seen in IDLE;
// freeze rises combinationally in that cycle and the requester must hold the
// request until done=1, after which it advances on the following edge. The
// port side holds portRd/portWr until portReady=1 (no timeout).
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int RD_WAIT_CYC  = 1,
    parameter int WR_PULSE_CYC = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        memReadIn,
    input  logic [1:0]        memWriteIn,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] wdataIn,
    output logic              freeze,
    output logic [DATA_W-1:0] rdataOut,
    output logic              done,
    output logic              accErr,
    output logic [ADDR_W-1:0] sramAddr,
    inout  wire  [DATA_W-1:0] sramData,
    output logic              sramCE_n,
    output logic              sramOE_n,
    output logic              sramWE_n,
    output logic              portAddr,
    output logic              portRd,
    output logic              portWr,
    output logic [DATA_W-1:0] portWdata,
    input  logic [DATA_W-1:0] portRdata,
    input  logic              portReady,
    output state_t            dbgState
);

    // OE_n stays low RD_WAIT_CYC+1 cycles: the extra cycle is the capture cycle.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT_CYC);
    // WE_n stays low exactly WR_PULSE_CYC cycles.
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE_CYC - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_acc_err;
    logic              r_err_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_port_addr;
    logic [DATA_W-1:0] r_port_wdata;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_drive;
    logic              r_port_rd;
    logic              r_port_wr;

    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_load_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    assign w_rd_req = is_access(memReadIn);
    assign w_wr_req = is_access(memWriteIn);

    // Freeze covers the request cycle itself and every busy state; reset forces it low.
    assign freeze = RST && (((r_state == ST_IDLE) && (w_rd_req || w_wr_req)) ||
                            ((r_state != ST_IDLE) && (r_state != ST_DONE)));

    // The bus is driven only in write states, never while OE_n is low.
    assign sramData = r_drive ? r_wdata : 'z;

    assign rdataOut  = r_rdata;
    assign done      = r_done;
    assign accErr    = r_acc_err;
    assign sramAddr  = r_addr;
    assign sramCE_n  = r_ce_n;
    assign sramOE_n  = r_oe_n;
    assign sramWE_n  = r_we_n;
    assign portAddr  = r_port_addr;
    assign portRd    = r_port_rd;
    assign portWr    = r_port_wr;
    assign portWdata = r_port_wdata;
    assign dbgState  = r_state;

    // Wait counter control: load on entry to a timed phase, count down inside it
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        case (r_state)
            ST_RD_SETUP: begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = RD_LOAD;
            end
            ST_WR_SETUP: begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = WR_LOAD;
            end
            ST_RD_WAIT, ST_WR_PULSE: w_cnt_dec = !w_cnt_zero;
            default: ;
        endcase
    end

    mem_wait_counter u_wait_counter (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Access FSM with registered strobes; reset aborts and releases the bus at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_rdata      <= '0;
            r_done       <= 1'b0;
            r_acc_err    <= 1'b0;
            r_err_pend   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_port_addr  <= 1'b0;
            r_port_wdata <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_drive      <= 1'b0;
            r_port_rd    <= 1'b0;
            r_port_wr    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_acc_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_req) begin
                        // Write wins over a simultaneous read; the conflict is flagged at DONE.
                        r_err_pend <= w_rd_req;
                        if (memWriteIn == ACC_SRAM) begin
                            r_addr  <= addrIn;
                            r_wdata <= wdataIn;
                            r_ce_n  <= 1'b0;
                            r_drive <= 1'b1;
                            r_state <= ST_WR_SETUP;
                        end else begin
                            r_port_addr  <= addrIn[0];
                            r_port_wdata <= wdataIn;
                            r_port_wr    <= 1'b1;
                            r_state      <= ST_PORT_WAIT;
                        end
                    end else if (w_rd_req) begin
                        r_err_pend <= 1'b0;
                        if (memReadIn == ACC_SRAM) begin
                            r_addr  <= addrIn;
                            r_ce_n  <= 1'b0;
                            r_state <= ST_RD_SETUP;
                        end else begin
                            r_port_addr <= addrIn[0];
                            r_port_rd   <= 1'b1;
                            r_state     <= ST_PORT_WAIT;
                        end
                    end
                end
                ST_RD_SETUP: begin
                    r_oe_n  <= 1'b0;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (w_cnt_zero) begin
                        r_rdata   <= sramData;
                        r_oe_n    <= 1'b1;
                        r_ce_n    <= 1'b1;
                        r_done    <= 1'b1;
                        r_acc_err <= r_err_pend;
                        r_state   <= ST_DONE;
                    end
                end
                ST_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_state <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (w_cnt_zero) begin
                        r_we_n  <= 1'b1;
                        r_state <= ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    r_ce_n    <= 1'b1;
                    r_drive   <= 1'b0;
                    r_done    <= 1'b1;
                    r_acc_err <= r_err_pend;
                    r_state   <= ST_DONE;
                end
                ST_PORT_WAIT: begin
                    if (portReady) begin
                        if (r_port_rd) begin
                            r_rdata <= portRdata;
                        end
                        r_port_rd <= 1'b0;
                        r_port_wr <= 1'b0;
                        r_done    <= 1'b1;
                        r_acc_err <= r_err_pend;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
